stream_sched: RTL and testbench

Round-robin scheduler sharing the single output stream port among `N` result producers. Each producer pulses a request when its result buffer is ready. The block latches requests, grants one producer at a time, and issues a burst of buffer read addresses gated by `dst_ready`. It generates the registered `dst_valid`/`dst_last` sideband and a per-producer completion pulse. It sits between the core result buffers and the stream output mux.

---
 rtl/stream_sched.sv | 133 +++++++++++++
 tb/tb_stream_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_sched.sv
`default_nettype none
// stream_sched: round-robin scheduler that grants N result producers the shared output
// stream and issues len+1 buffer read addresses per grant under dst_ready flow control.
module stream_sched #(
   parameter int N  = 4,
   parameter int AW = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [AW-1:0]        len,
   input  logic                 dst_ready,
   output logic                 dst_valid,
   output logic                 dst_last,
   output logic                 rd_v,
   output logic [AW-1:0]        rd_a,
   output logic [$clog2(N)-1:0] rd_sel,
   output logic [N-1:0]         gnt,
   output logic [N-1:0]         done,
   output logic                 busy
);
   localparam int SW = $clog2(N);
   localparam int IW = SW + 1;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [N-1:0]  pending;
   logic [SW-1:0] ptr;
   logic [AW-1:0] cnt;
   logic [AW-1:0] len_q;
   logic [SW-1:0] winner;
   logic          found;
   logic [IW-1:0] idx;
   logic          take;
   logic          beat_last;
   logic          burst_end;
   logic [N-1:0]  win_oh;
   logic [N-1:0]  sel_oh;

   // Search upward from ptr with wrap; the extra index bit absorbs ptr+i overflow.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int i = 0; i < N; i++) begin
         idx = {1'b0, ptr} + IW'(i);
         if (idx >= IW'(N)) begin
            idx = idx - IW'(N);
         end
         if (!found && pending[idx[SW-1:0]]) begin
            found  = 1'b1;
            winner = idx[SW-1:0];
         end
      end
   end

   assign win_oh    = {{(N-1){1'b0}}, 1'b1} << winner;
   assign sel_oh    = {{(N-1){1'b0}}, 1'b1} << rd_sel;
   assign beat_last = (cnt == len_q);
   assign burst_end = rd_v & beat_last;
   assign rd_a      = cnt;
   assign busy      = (state == STREAM) | (|pending);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rd_v      = 1'b0;
      take      = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               take      = 1'b1;
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            rd_v = dst_ready;
            if (dst_ready && beat_last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending   <= '0;
         ptr       <= '0;
         cnt       <= '0;
         len_q     <= '0;
         gnt       <= '0;
         rd_sel    <= '0;
         done      <= '0;
         dst_valid <= 1'b0;
         dst_last  <= 1'b0;
      end else begin
         // A request arriving with its own grant re-arms the bit as a new job.
         pending <= (pending & ~({N{take}} & win_oh)) | req;
         done    <= burst_end ? sel_oh : '0;
         if (take) begin
            gnt    <= win_oh;
            rd_sel <= winner;
            len_q  <= len;
            cnt    <= '0;
            ptr    <= (winner == SW'(N - 1)) ? '0 : winner + SW'(1);
         end else if (rd_v) begin
            if (beat_last) begin
               gnt <= '0;
            end else begin
               cnt <= cnt + AW'(1);
            end
         end
         if (dst_ready) begin
            dst_valid <= rd_v;
            dst_last  <= burst_end;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_stream_sched.sv
`default_nettype none
// tb_stream_sched: directed self-checking bench for stream_sched (N=4, AW=8).
module tb_stream_sched;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [7:0] len;
   logic       dst_ready;
   logic       dst_valid;
   logic       dst_last;
   logic       rd_v;
   logic [7:0] rd_a;
   logic [1:0] rd_sel;
   logic [3:0] gnt;
   logic [3:0] done;
   logic       busy;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   stream_sched #(.N(4), .AW(8)) dut (
      .clk(clk), .rst(rst), .req(req), .len(len), .dst_ready(dst_ready),
      .dst_valid(dst_valid), .dst_last(dst_last), .rd_v(rd_v), .rd_a(rd_a),
      .rd_sel(rd_sel), .gnt(gnt), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // rd_a and rd_sel are only meaningful while a grant is held.
   task automatic expect_out(input string tag, input logic [3:0] g, input logic v,
                             input logic [7:0] a, input logic dv, input logic dl,
                             input logic [3:0] dn);
      logic [1:0] s;
      s = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (g[i]) s = 2'(i);
      end
      check({tag, "_gnt"}, 32'(gnt), 32'(g));
      check({tag, "_rd_v"}, 32'(rd_v), 32'(v));
      if (g != 4'd0) begin
         check({tag, "_rd_a"}, 32'(rd_a), 32'(a));
         check({tag, "_rd_sel"}, 32'(rd_sel), 32'(s));
      end
      check({tag, "_dst_valid"}, 32'(dst_valid), 32'(dv));
      check({tag, "_dst_last"}, 32'(dst_last), 32'(dl));
      check({tag, "_done"}, 32'(done), 32'(dn));
   endtask

   logic [3:0] order [3];
   int         acc;
   int         last_at;
   logic       rdy;
   logic [7:0] ea;

   initial begin
      rst       = 1'b0;
      req       = 4'd0;
      len       = 8'd0;
      dst_ready = 1'b1;
      step();
      step();
      expect_out("reset", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_rd_sel", 32'(rd_sel), 32'd0);
      rst = 1'b1;
      step();

      // single request, len=3
      req = 4'b0001;
      len = 8'd3;
      #1;
      check("t1_idle_busy", 32'(busy), 32'd0);
      step();
      req = 4'd0;
      check("t1_pend_busy", 32'(busy), 32'd1);
      check("t1_pend_rd_v", 32'(rd_v), 32'd0);
      step();
      for (int k = 0; k < 4; k++) begin
         expect_out("t1_beat", 4'b0001, 1'b1, 8'(k), (k > 0), 1'b0, 4'd0);
         step();
      end
      expect_out("t1_end", 4'd0, 1'b0, 8'd0, 1'b1, 1'b1, 4'b0001);
      step();
      expect_out("t1_after", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0);
      check("t1_after_busy", 32'(busy), 32'd0);

      // simultaneous requests after reset, 1-beat bursts
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
      req = 4'b1011;
      len = 8'd0;
      step();
      req = 4'd0;
      check("t2_busy", 32'(busy), 32'd1);
      step();
      order[0] = 4'b0001;
      order[1] = 4'b0010;
      order[2] = 4'b1000;
      for (int k = 0; k < 3; k++) begin
         expect_out("t2_grant", order[k], 1'b1, 8'd0, 1'b0, 1'b0, 4'd0);
         step();
         expect_out("t2_beat", 4'd0, 1'b0, 8'd0, 1'b1, 1'b1, order[k]);
         step();
      end
      check("t2_busy_end", 32'(busy), 32'd0);
      check("t2_valid_end", 32'(dst_valid), 32'd0);

      // 3-cycle stall mid-burst, len=7
      req = 4'b0001;
      len = 8'd7;
      step();
      req = 4'd0;
      step();
      acc     = 0;
      last_at = 0;
      for (int c = 0; c < 12; c++) begin
         rdy       = !(c >= 4 && c <= 6);
         dst_ready = rdy;
         #1;
         if (c < 4) ea = 8'(c);
         else if (c <= 6) ea = 8'd4;
         else ea = 8'(c - 3);
         expect_out("t3_cyc", (c <= 10) ? 4'b0001 : 4'd0, (c <= 10) && rdy, ea,
                    (c >= 1), (c == 11), (c == 11) ? 4'b0001 : 4'd0);
         if (dst_valid && dst_ready) acc++;
         if (dst_last && dst_ready) last_at = acc;
         step();
      end
      dst_ready = 1'b1;
      check("t3_beats", 32'(acc), 32'd8);
      check("t3_last_at", 32'(last_at), 32'd8);

      // req[2] re-pulsed in its grant cycle, req[1] joins: served 2,1,2
      req = 4'b0100;
      len = 8'd0;
      step();
      req = 4'b0110;
      step();
      req = 4'd0;
      order[0] = 4'b0100;
      order[1] = 4'b0010;
      order[2] = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         expect_out("t4_grant", order[k], 1'b1, 8'd0, 1'b0, 1'b0, 4'd0);
         step();
         expect_out("t4_beat", 4'd0, 1'b0, 8'd0, 1'b1, 1'b1, order[k]);
         step();
      end
      check("t4_busy_end", 32'(busy), 32'd0);

      // maximum length burst, len changed mid-burst
      req = 4'b0001;
      len = 8'd255;
      step();
      req = 4'd0;
      step();
      for (int c = 0; c < 256; c++) begin
         if (c == 10) len = 8'd5;
         expect_out("t5_beat", 4'b0001, 1'b1, 8'(c), (c > 0), 1'b0, 4'd0);
         step();
      end
      expect_out("t5_end", 4'd0, 1'b0, 8'd0, 1'b1, 1'b1, 4'b0001);

      // asynchronous reset during beat 2, with another request pending
      step();
      req = 4'b1010;
      len = 8'd5;
      step();
      req = 4'd0;
      step();
      step();
      step();
      expect_out("t6_beat2", 4'b0010, 1'b1, 8'd2, 1'b1, 1'b0, 4'd0);
      rst = 1'b0;
      #1;
      expect_out("t6_async", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0);
      check("t6_async_busy", 32'(busy), 32'd0);
      check("t6_async_rd_sel", 32'(rd_sel), 32'd0);
      step();
      rst = 1'b1;
      step();
      step();
      step();
      expect_out("t6_idle", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0);
      check("t6_idle_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
`default_nettype wire
